// File: rtl/custom_master_slave_ctrl.sv
// Register-programmed burst sequencer. A write to COUNT starts a burst.
// Each transfer is an address strobe followed by a data strobe, with optional idle gaps between transfers.
module custom_master_slave_ctrl #(
  parameter int ADDR_W = 26,
  parameter int DATA_W = 32
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              slave_write,
  input  logic              slave_chipselect,
  input  logic [2:0]        slave_address,
  input  logic [DATA_W-1:0] slave_writedata,
  output logic              rdwr_cntl,
  output logic              n_action,
  output logic              add_data_sel,
  output logic [ADDR_W-1:0] rdwr_address
);

  typedef enum logic [1:0] {
    S_IDLE,
    S_ADDR,
    S_DATA,
    S_GAP
  } state_e;

  state_e state_q, state_d;

  logic              ctrl_q;
  logic [ADDR_W-1:0] base_q;
  logic [7:0]        gap_q;
  logic [15:0]       count_q;

  logic [15:0]       rem_q, rem_d;
  logic [7:0]        gcnt_q, gcnt_d;
  logic [7:0]        wgap_q, wgap_d;
  logic [ADDR_W-1:0] addr_q, addr_d;
  logic              dir_q, dir_d;
  logic              nact_q, nact_d;
  logic              sel_q, sel_d;

  logic we;
  logic launch;

  assign we     = slave_chipselect & slave_write;
  assign launch = we && (slave_address == 3'd3) &&
                  (state_q == S_IDLE) &&
                  (slave_writedata[15:0] != 16'd0);

  // Host-visible registers; COUNT is only stored while idle.
  always_ff @(posedge clk) begin
    if (reset) begin
      ctrl_q  <= 1'b0;
      base_q  <= '0;
      gap_q   <= '0;
      count_q <= '0;
    end else if (we) begin
      case (slave_address)
        3'd0: ctrl_q <= slave_writedata[0];
        3'd1: base_q <= slave_writedata[ADDR_W-1:0];
        3'd2: gap_q  <= slave_writedata[7:0];
        3'd3: if (state_q == S_IDLE)
                count_q <= slave_writedata[15:0];
        default: ;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= S_IDLE;
      rem_q   <= '0;
      gcnt_q  <= '0;
      wgap_q  <= '0;
      addr_q  <= '0;
      dir_q   <= 1'b0;
      nact_q  <= 1'b1;
      sel_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      rem_q   <= rem_d;
      gcnt_q  <= gcnt_d;
      wgap_q  <= wgap_d;
      addr_q  <= addr_d;
      dir_q   <= dir_d;
      nact_q  <= nact_d;
      sel_q   <= sel_d;
    end
  end

  always_comb begin
    state_d = state_q;
    rem_d   = rem_q;
    gcnt_d  = gcnt_q;
    unique case (state_q)
      S_IDLE: begin
        if (launch) begin
          state_d = S_ADDR;
          rem_d   = slave_writedata[15:0];
        end
      end
      S_ADDR: state_d = S_DATA;
      S_DATA: begin
        rem_d = rem_q - 16'd1;
        if (rem_q == 16'd1) begin
          state_d = S_IDLE;
        end else if (wgap_q == 8'd0) begin
          state_d = S_ADDR;
        end else begin
          state_d = S_GAP;
          gcnt_d  = wgap_q;
        end
      end
      S_GAP: begin
        if (gcnt_q <= 8'd1) state_d = S_ADDR;
        else                gcnt_d  = gcnt_q - 8'd1;
      end
      default: state_d = S_IDLE;
    endcase
  end

  // Outputs are decoded from the next state so they appear registered.
  always_comb begin
    addr_d = addr_q;
    dir_d  = dir_q;
    wgap_d = wgap_q;
    if (launch) begin
      addr_d = base_q;
      dir_d  = ctrl_q;
      wgap_d = gap_q;
    end else if (state_q == S_DATA && rem_q != 16'd1) begin
      addr_d = addr_q + 1'b1;
    end
    nact_d = !(state_d == S_ADDR || state_d == S_DATA);
    sel_d  = (state_d == S_DATA);
  end

  assign rdwr_cntl    = dir_q;
  assign n_action     = nact_q;
  assign add_data_sel = sel_q;
  assign rdwr_address = addr_q;

  logic unused_bits;
  assign unused_bits = ^{count_q, slave_writedata[DATA_W-1:ADDR_W]};

endmodule

// File: tb/tb_custom_master_slave_ctrl.sv
// Randomised and directed bench for custom_master_slave_ctrl.
// The bench compares the DUT outputs cycle by cycle with a per-burst trace model.
module tb_custom_master_slave_ctrl;

  logic        clk = 1'b0;
  logic        reset;
  logic        slave_write;
  logic        slave_chipselect;
  logic [2:0]  slave_address;
  logic [31:0] slave_writedata;
  logic        rdwr_cntl;
  logic        n_action;
  logic        add_data_sel;
  logic [25:0] rdwr_address;

  custom_master_slave_ctrl #(.ADDR_W(26), .DATA_W(32)) dut (
    .clk              (clk),
    .reset            (reset),
    .slave_write      (slave_write),
    .slave_chipselect (slave_chipselect),
    .slave_address    (slave_address),
    .slave_writedata  (slave_writedata),
    .rdwr_cntl        (rdwr_cntl),
    .n_action         (n_action),
    .add_data_sel     (add_data_sel),
    .rdwr_address     (rdwr_address)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic        n;
    logic        s;
    logic [25:0] a;
    logic        d;
  } cyc_t;

  cyc_t exp_q[$];
  cyc_t obs;

  int errors = 0;
  int checks = 0;

  logic        m_ctrl;
  logic [25:0] m_base;
  logic [7:0]  m_gap;
  logic [25:0] m_last;
  logic        m_dir;

  function automatic cyc_t cur();
    cyc_t c;
    c.n = n_action;
    c.s = add_data_sel;
    c.a = rdwr_address;
    c.d = rdwr_cntl;
    return c;
  endfunction

  function automatic void model_reset();
    m_ctrl = 1'b0;
    m_base = '0;
    m_gap  = '0;
    m_last = '0;
    m_dir  = 1'b0;
  endfunction

  // Expected per-cycle trace of one burst, followed by idle cycles
  task automatic build(input logic d, input logic [25:0] b,
                       input int g, input int n, input int idle);
    logic [25:0] a;
    logic [25:0] a1;
    exp_q.delete();
    for (int i = 0; i < n; i++) begin
      a  = b + 26'(i);
      a1 = a + 26'd1;
      exp_q.push_back('{1'b0, 1'b0, a, d});
      exp_q.push_back('{1'b0, 1'b1, a, d});
      if (i < n - 1)
        for (int k = 0; k < g; k++)
          exp_q.push_back('{1'b1, 1'b0, a1, d});
    end
    m_last = b + 26'(n - 1);
    m_dir  = d;
    for (int k = 0; k < idle; k++)
      exp_q.push_back('{1'b1, 1'b0, m_last, d});
  endtask

  task automatic wr(input logic [2:0] a, input logic [31:0] d,
                    input bit cs = 1'b1);
    slave_chipselect = cs;
    slave_write      = 1'b1;
    slave_address    = a;
    slave_writedata  = d;
    @(negedge clk);
    slave_chipselect = 1'b0;
    slave_write      = 1'b0;
    if (cs) begin
      case (a)
        3'd0: m_ctrl = d[0];
        3'd1: m_base = d[25:0];
        3'd2: m_gap  = d[7:0];
        default: ;
      endcase
    end
  endtask

  task automatic test_reset();
    reset = 1'b1;
    @(negedge clk);
    obs = cur();
    checks++;
    if (obs !== 29'({1'b1, 1'b0, 26'd0, 1'b0})) begin
      errors++;
      $display("FAIL reset: got %h exp %h", obs, {1'b1, 1'b0, 26'd0, 1'b0});
    end
    reset = 1'b0;
    model_reset();
  endtask

  task automatic test_gap0();
    wr(3'd0, 32'd0);
    wr(3'd1, 32'd584);
    wr(3'd2, 32'd0);
    wr(3'd3, 32'd22);
    build(1'b0, 26'd584, 0, 22, 3);
    foreach (exp_q[i]) begin
      obs = cur();
      checks++;
      if (obs !== exp_q[i]) begin
        errors++;
        $display("FAIL gap0 cyc %0d: got %h exp %h", i, obs, exp_q[i]);
      end
      @(negedge clk);
    end
  endtask

  task automatic test_gap();
    wr(3'd0, 32'd1);
    wr(3'd1, 32'd10);
    wr(3'd2, 32'd2);
    wr(3'd3, 32'd3);
    build(1'b1, 26'd10, 2, 3, 3);
    foreach (exp_q[i]) begin
      obs = cur();
      checks++;
      if (obs !== exp_q[i]) begin
        errors++;
        $display("FAIL gap cyc %0d: got %h exp %h", i, obs, exp_q[i]);
      end
      @(negedge clk);
    end
  endtask

  task automatic test_ignored();
    wr(3'd3, 32'd0);
    wr(3'd1, 32'd1234, 1'b0);
    wr(3'd3, 32'd5, 1'b0);
    wr(3'd5, 32'd999);
    wr(3'd7, 32'd4);
    for (int i = 0; i < 6; i++) begin
      obs = cur();
      checks++;
      if (obs !== 29'({1'b1, 1'b0, m_last, m_dir})) begin
        errors++;
        $display("FAIL ignored idle %0d: got %h exp %h", i, obs,
                 {1'b1, 1'b0, m_last, m_dir});
      end
      @(negedge clk);
    end
    wr(3'd3, 32'd2);
    build(m_ctrl, m_base, int'(m_gap), 2, 2);
    foreach (exp_q[i]) begin
      obs = cur();
      checks++;
      if (obs !== exp_q[i]) begin
        errors++;
        $display("FAIL ignored burst cyc %0d: got %h exp %h", i, obs, exp_q[i]);
      end
      @(negedge clk);
    end
  endtask

  task automatic test_wrap();
    wr(3'd0, 32'd0);
    wr(3'd1, 32'h03FF_FFFF);
    wr(3'd2, 32'd0);
    wr(3'd3, 32'd2);
    build(1'b0, 26'h3FF_FFFF, 0, 2, 2);
    foreach (exp_q[i]) begin
      obs = cur();
      checks++;
      if (obs !== exp_q[i]) begin
        errors++;
        $display("FAIL wrap cyc %0d: got %h exp %h", i, obs, exp_q[i]);
      end
      @(negedge clk);
    end
  endtask

  task automatic test_busy();
    wr(3'd0, 32'd1);
    wr(3'd1, 32'd300);
    wr(3'd2, 32'd1);
    wr(3'd3, 32'd5);
    build(1'b1, 26'd300, 1, 5, 2);
    foreach (exp_q[i]) begin
      obs = cur();
      checks++;
      if (obs !== exp_q[i]) begin
        errors++;
        $display("FAIL busy cyc %0d: got %h exp %h", i, obs, exp_q[i]);
      end
      slave_chipselect = (i == 3 || i == 4);
      slave_write      = (i == 3 || i == 4);
      slave_address    = (i == 3) ? 3'd3 : 3'd1;
      slave_writedata  = (i == 3) ? 32'd9 : 32'd777;
      @(negedge clk);
    end
    slave_chipselect = 1'b0;
    slave_write      = 1'b0;
    m_base = 26'd777;
    wr(3'd3, 32'd2);
    build(m_ctrl, m_base, int'(m_gap), 2, 2);
    foreach (exp_q[i]) begin
      obs = cur();
      checks++;
      if (obs !== exp_q[i]) begin
        errors++;
        $display("FAIL busy next cyc %0d: got %h exp %h", i, obs, exp_q[i]);
      end
      @(negedge clk);
    end
    // Reset in the middle of a burst, then verify the registers were cleared
    wr(3'd3, 32'd6);
    repeat (3) @(negedge clk);
    reset = 1'b1;
    @(negedge clk);
    reset = 1'b0;
    obs = cur();
    checks++;
    if (obs !== 29'({1'b1, 1'b0, 26'd0, 1'b0})) begin
      errors++;
      $display("FAIL midreset: got %h exp %h", obs, {1'b1, 1'b0, 26'd0, 1'b0});
    end
    model_reset();
    @(negedge clk);
    wr(3'd3, 32'd2);
    build(1'b0, 26'd0, 0, 2, 2);
    foreach (exp_q[i]) begin
      obs = cur();
      checks++;
      if (obs !== exp_q[i]) begin
        errors++;
        $display("FAIL postreset cyc %0d: got %h exp %h", i, obs, exp_q[i]);
      end
      @(negedge clk);
    end
  endtask

  task automatic test_random();
    logic [25:0] b;
    int g;
    int n;
    for (int t = 0; t < 8; t++) begin
      b = 26'($urandom);
      if (t % 3 == 0) b = 26'h3FF_FFFF - 26'($urandom_range(0, 3));
      g = $urandom_range(0, 3);
      n = $urandom_range(1, 8);
      wr(3'd0, $urandom);
      wr(3'd1, {6'($urandom), b});
      wr(3'd2, {24'($urandom), 8'(g)});
      wr(3'd3, {16'($urandom), 16'(n)});
      build(m_ctrl, b, g, n, 2);
      foreach (exp_q[i]) begin
        obs = cur();
        checks++;
        if (obs !== exp_q[i]) begin
          errors++;
          $display("FAIL random %0d cyc %0d: got %h exp %h", t, i, obs, exp_q[i]);
        end
        @(negedge clk);
      end
    end
  endtask

  initial begin
    reset            = 1'b1;
    slave_write      = 1'b0;
    slave_chipselect = 1'b0;
    slave_address    = '0;
    slave_writedata  = '0;
    model_reset();
    test_reset();
    test_gap0();
    test_gap();
    test_ignored();
    test_wrap();
    test_busy();
    test_random();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
